// File: rtl/flit_receiver.sv
// rtl/flit_receiver.sv - NoC flit sink: per-VC packet reassembly, framing checks, toggle stats
module flit_receiver #(
    parameter int FLITW = 66,
    parameter int TYPEW = 2,
    parameter int VCHN  = 2,
    parameter int VCHW  = 1,
    parameter int LENW  = 8,
    parameter int TOGW  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FLITW-1:0] idata,
    input  logic             ivalid,
    input  logic [VCHW-1:0]  ivch,
    input  logic             clr,
    output logic             pkt_done,
    output logic [VCHW-1:0]  pkt_vch,
    output logic [LENW-1:0]  pkt_len,
    output logic [31:0]      pkt_dst,
    output logic             err_proto,
    output logic             err_vch,
    output logic [15:0]      pkt_cnt,
    output logic [TOGW-1:0]  toggle_cnt,
    output logic             busy
);

    localparam int PW  = FLITW - TYPEW;
    localparam int TSW = TOGW + 1;

    localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_DATA = TYPEW'(2);

    typedef enum logic {VC_IDLE = 1'b0, VC_BODY = 1'b1} vc_state_e;

    vc_state_e         state_q [VCHN];
    vc_state_e         state_d [VCHN];
    logic [LENW-1:0]   len_q   [VCHN];
    logic [LENW-1:0]   len_d   [VCHN];
    logic [31:0]       dst_q   [VCHN];
    logic [31:0]       dst_d   [VCHN];

    logic [PW-1:0]     prev_q, prev_d, prev_base, payload;
    logic [TOGW-1:0]   toggle_q, toggle_d, tog_base;
    logic [TSW-1:0]    tog_sum;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic              pkt_done_q, pkt_done_d;
    logic [VCHW-1:0]   pkt_vch_q, pkt_vch_d;
    logic [LENW-1:0]   pkt_len_q, pkt_len_d, len_inc;
    logic [31:0]       pkt_dst_q, pkt_dst_d;
    logic              err_proto_q, err_proto_d;
    logic              err_vch_q, err_vch_d;
    logic [TYPEW-1:0]  ftype;
    logic              flit_valid, vch_ok, take, busy_c;

    // Decode the incoming flit and compute next state of every VC and the statistics
    always_comb begin
        ftype       = idata[FLITW-1 -: TYPEW];
        payload     = idata[PW-1:0];
        vch_ok      = ({{(32-VCHW){1'b0}}, ivch} < 32'(VCHN));
        flit_valid  = ivalid && (ftype != T_NONE);
        take        = flit_valid && vch_ok;
        err_vch_d   = flit_valid && !vch_ok;
        pkt_done_d  = 1'b0;
        err_proto_d = 1'b0;
        pkt_vch_d   = pkt_vch_q;
        pkt_len_d   = pkt_len_q;
        pkt_dst_d   = pkt_dst_q;
        len_inc     = '0;
        for (int v = 0; v < VCHN; v++) begin
            state_d[v] = state_q[v];
            len_d[v]   = len_q[v];
            dst_d[v]   = dst_q[v];
            len_inc    = (len_q[v] == '1) ? len_q[v] : len_q[v] + 1'b1;
            if (take && (ivch == VCHW'(v))) begin
                if (ftype == T_HEAD) begin
                    // A HEAD inside a packet abandons the old one silently except for the error
                    err_proto_d = (state_q[v] == VC_BODY);
                    state_d[v]  = VC_BODY;
                    len_d[v]    = LENW'(1);
                    dst_d[v]    = payload[31:0];
                end else if (state_q[v] == VC_IDLE) begin
                    err_proto_d = 1'b1;
                end else if (ftype == T_DATA) begin
                    len_d[v] = len_inc;
                end else begin
                    state_d[v] = VC_IDLE;
                    len_d[v]   = len_inc;
                    pkt_done_d = 1'b1;
                    pkt_vch_d  = ivch;
                    pkt_len_d  = len_inc;
                    pkt_dst_d  = dst_q[v];
                end
            end
        end
        // Clear takes effect first so a same-cycle flit counts against a zero history
        prev_base = clr ? '0 : prev_q;
        tog_base  = clr ? '0 : toggle_q;
        tog_sum   = {1'b0, tog_base} + TSW'($countones(payload ^ prev_base));
        if (take) begin
            toggle_d = tog_sum[TOGW] ? '1 : tog_sum[TOGW-1:0];
            prev_d   = payload;
        end else begin
            toggle_d = tog_base;
            prev_d   = prev_base;
        end
        pkt_cnt_d = clr ? 16'h0 : pkt_cnt_q;
        if (pkt_done_d && (pkt_cnt_d != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_d + 16'h1;
        end
    end

    // Register per-VC state, statistics and all outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VCHN; v++) begin
                state_q[v] <= VC_IDLE;
                len_q[v]   <= '0;
                dst_q[v]   <= '0;
            end
            prev_q      <= '0;
            toggle_q    <= '0;
            pkt_cnt_q   <= '0;
            pkt_done_q  <= 1'b0;
            pkt_vch_q   <= '0;
            pkt_len_q   <= '0;
            pkt_dst_q   <= '0;
            err_proto_q <= 1'b0;
            err_vch_q   <= 1'b0;
        end else begin
            for (int v = 0; v < VCHN; v++) begin
                state_q[v] <= state_d[v];
                len_q[v]   <= len_d[v];
                dst_q[v]   <= dst_d[v];
            end
            prev_q      <= prev_d;
            toggle_q    <= toggle_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_done_q  <= pkt_done_d;
            pkt_vch_q   <= pkt_vch_d;
            pkt_len_q   <= pkt_len_d;
            pkt_dst_q   <= pkt_dst_d;
            err_proto_q <= err_proto_d;
            err_vch_q   <= err_vch_d;
        end
    end

    // Busy reflects the registered VC states directly
    always_comb begin
        busy_c = 1'b0;
        for (int v = 0; v < VCHN; v++) begin
            busy_c = busy_c | (state_q[v] == VC_BODY);
        end
    end

    assign busy       = busy_c;
    assign pkt_done   = pkt_done_q;
    assign pkt_vch    = pkt_vch_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_dst    = pkt_dst_q;
    assign err_proto  = err_proto_q;
    assign err_vch    = err_vch_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign toggle_cnt = toggle_q;

endmodule

// File: tb/tb_flit_receiver.sv
// tb/tb_flit_receiver.sv - directed self-checking bench for flit_receiver
module tb_flit_receiver;

    localparam int FLITW = 66;
    localparam int VCHW  = 2;
    localparam int LENW  = 8;
    localparam int TOGW  = 24;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] DATA = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    logic             clk;
    logic             rst;
    logic [FLITW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;
    logic             clr;
    logic             pkt_done;
    logic [VCHW-1:0]  pkt_vch;
    logic [LENW-1:0]  pkt_len;
    logic [31:0]      pkt_dst;
    logic             err_proto;
    logic             err_vch;
    logic [15:0]      pkt_cnt;
    logic [TOGW-1:0]  toggle_cnt;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    flit_receiver #(
        .FLITW(FLITW), .TYPEW(2), .VCHN(2), .VCHW(VCHW), .LENW(LENW), .TOGW(TOGW)
    ) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
        .pkt_done(pkt_done), .pkt_vch(pkt_vch), .pkt_len(pkt_len), .pkt_dst(pkt_dst),
        .err_proto(err_proto), .err_vch(err_vch), .pkt_cnt(pkt_cnt),
        .toggle_cnt(toggle_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one flit at a falling edge; outputs seen afterwards belong to the previous flit
    task automatic send(input logic [1:0] t, input logic [VCHW-1:0] v, input logic [63:0] p);
        @(negedge clk);
        ivalid = 1'b1;
        ivch   = v;
        idata  = {t, p};
    endtask

    task automatic idle();
        @(negedge clk);
        ivalid = 1'b0;
        idata  = '0;
        ivch   = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 64'(pkt_done), 64'd0);
        check({tag, "_len"}, 64'(pkt_len), 64'd0);
        check({tag, "_dst"}, 64'(pkt_dst), 64'd0);
        check({tag, "_vch"}, 64'(pkt_vch), 64'd0);
        check({tag, "_cnt"}, 64'(pkt_cnt), 64'd0);
        check({tag, "_tog"}, 64'(toggle_cnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_errp"}, 64'(err_proto), 64'd0);
        check({tag, "_errv"}, 64'(err_vch), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ivalid = 1'b0; idata = '0; ivch = '0; clr = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("rst0");
        rst = 1'b0;

        // Long packet on vch0
        send(HEAD, 0, 64'h09);
        for (int i = 0; i < 20; i++) send(DATA, 0, 64'(i));
        send(TAIL, 0, 64'h0);
        check("t1_busy_before", 64'(busy), 64'd1);
        idle();
        check("t1_done", 64'(pkt_done), 64'd1);
        check("t1_len", 64'(pkt_len), 64'd22);
        check("t1_dst", 64'(pkt_dst), 64'h09);
        check("t1_vch", 64'(pkt_vch), 64'd0);
        check("t1_cnt", 64'(pkt_cnt), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        idle();
        check("t1_done_pulse", 64'(pkt_done), 64'd0);
        check("t1_len_hold", 64'(pkt_len), 64'd22);

        // Toggle accounting: 0 -> all-ones -> 0 gives 64 + 64
        do_reset();
        send(HEAD, 0, 64'h0);
        send(DATA, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        send(TAIL, 0, 64'h0);
        idle();
        check("t2_tog", 64'(toggle_cnt), 64'd128);
        check("t2_cnt", 64'(pkt_cnt), 64'd1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("t2_clr_tog", 64'(toggle_cnt), 64'd0);
        check("t2_clr_cnt", 64'(pkt_cnt), 64'd0);

        // DATA on idle vch1 (payload equals history so toggles stay put)
        send(DATA, 1, 64'h0);
        idle();
        check("t3_errp", 64'(err_proto), 64'd1);
        check("t3_done", 64'(pkt_done), 64'd0);
        check("t3_cnt", 64'(pkt_cnt), 64'd0);
        check("t3_tog", 64'(toggle_cnt), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        idle();
        check("t3_errp_pulse", 64'(err_proto), 64'd0);

        // HEAD inside a packet restarts it
        send(HEAD, 0, 64'h04);
        send(DATA, 0, 64'h04);
        check("t4_errp_quiet", 64'(err_proto), 64'd0);
        send(HEAD, 0, 64'h07);
        send(TAIL, 0, 64'h07);
        check("t4_errp", 64'(err_proto), 64'd1);
        check("t4_nodone", 64'(pkt_done), 64'd0);
        idle();
        check("t4_done", 64'(pkt_done), 64'd1);
        check("t4_len", 64'(pkt_len), 64'd2);
        check("t4_dst", 64'(pkt_dst), 64'h07);
        check("t4_errp_clear", 64'(err_proto), 64'd0);
        check("t4_cnt", 64'(pkt_cnt), 64'd1);

        // Interleaved VCs; toggles 1 (0->0x10) + 1 (0x10->0x11) = 2
        do_reset();
        send(HEAD, 0, 64'h10);
        send(HEAD, 1, 64'h11);
        send(DATA, 0, 64'h11);
        send(TAIL, 1, 64'h11);
        send(TAIL, 0, 64'h11);
        check("t5_done1", 64'(pkt_done), 64'd1);
        check("t5_vch1", 64'(pkt_vch), 64'd1);
        check("t5_len1", 64'(pkt_len), 64'd2);
        check("t5_dst1", 64'(pkt_dst), 64'h11);
        idle();
        check("t5_done0", 64'(pkt_done), 64'd1);
        check("t5_vch0", 64'(pkt_vch), 64'd0);
        check("t5_len0", 64'(pkt_len), 64'd3);
        check("t5_dst0", 64'(pkt_dst), 64'h10);
        check("t5_cnt", 64'(pkt_cnt), 64'd2);
        check("t5_tog", 64'(toggle_cnt), 64'd2);

        // Out-of-range VC is dropped and leaves the toggle history alone
        send(HEAD, 2, 64'hFF);
        idle();
        check("t5_errv", 64'(err_vch), 64'd1);
        check("t5_errv_busy", 64'(busy), 64'd0);
        check("t5_errv_tog", 64'(toggle_cnt), 64'd2);
        check("t5_errv_errp", 64'(err_proto), 64'd0);
        send(HEAD, 0, 64'h10);
        idle();
        check("t5_errv_pulse", 64'(err_vch), 64'd0);
        check("t5_prev_kept", 64'(toggle_cnt), 64'd3);
        check("t5_busy", 64'(busy), 64'd1);

        // Length saturates at 255
        do_reset();
        send(HEAD, 1, 64'h0);
        for (int i = 0; i < 300; i++) send(DATA, 1, 64'h0);
        send(TAIL, 1, 64'h0);
        idle();
        check("t6_sat_len", 64'(pkt_len), 64'd255);
        check("t6_sat_done", 64'(pkt_done), 64'd1);

        // Reset mid-packet
        do_reset();
        send(HEAD, 0, 64'h0);
        for (int i = 0; i < 5; i++) send(DATA, 0, 64'h0);
        idle();
        check("t7_busy_pre", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("t7_inrst");
        @(negedge clk);
        rst = 1'b0;
        send(TAIL, 0, 64'h0);
        idle();
        check("t7_errp", 64'(err_proto), 64'd1);
        check("t7_nodone", 64'(pkt_done), 64'd0);
        check("t7_cnt", 64'(pkt_cnt), 64'd0);
        check("t7_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
